// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: read-arbiter FSM states and response encodings.
package axi4_lite_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_arbiter_core.sv
// Combinational round-robin select: the first set request after i_last (modulo N_REQ) wins.
module rr_arbiter_core #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_last,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_valid
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  int unsigned w_best;
  int unsigned w_dist;

  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    w_best = N_REQ;
    w_dist = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      // Distance from the slot just after i_last; smallest distance has priority.
      w_dist = (i + N_REQ - 32'(i_last) - 1) % N_REQ;
      if (i_req[i] && (w_dist < w_best)) begin
        w_best   = w_dist;
        o_gnt    = '0;
        o_gnt[i] = 1'b1;
        o_idx    = IDX_W'(i);
      end
    end
    o_valid = (w_best != N_REQ);
  end

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Shares one AXI4-Lite read port among N_REQ requesters, round-robin, one transaction in flight.
module axi4_lite_read_arbiter
  import axi4_lite_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [N_REQ-1:0]        REQ,
  input  logic [N_REQ*ADDR_W-1:0] REQ_ADDR,
  input  logic [N_REQ*3-1:0]      REQ_PROT,
  output logic [N_REQ-1:0]        GNT,
  output logic [N_REQ-1:0]        DONE,
  output logic [DATA_W-1:0]       USR_RDATA,
  output logic [1:0]              USR_RRESP,
  output logic                    BUSY,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  output logic [ADDR_W-1:0]       ARADDR,
  output logic [2:0]              ARPROT,
  input  logic                    RVALID,
  output logic                    RREADY,
  input  logic [DATA_W-1:0]       RDATA,
  input  logic [1:0]              RRESP
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  rd_arb_state_t     r_state;
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_done;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_usr_rdata;
  logic [1:0]        r_usr_rresp;
  logic              r_busy;
  logic              r_arvalid;
  logic [ADDR_W-1:0] r_araddr;
  logic [2:0]        r_arprot;
  logic              r_rready;

  logic [N_REQ-1:0]  w_gnt;
  logic [IDX_W-1:0]  w_idx;
  logic              w_any;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_prot;

  rr_arbiter_core #(
    .N_REQ (N_REQ)
  ) u_rr (
    .i_req   (REQ),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_any)
  );

  // One-hot mux of the winning requester's address and protection slices.
  always_comb begin
    w_addr = '0;
    w_prot = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_addr = REQ_ADDR[i*ADDR_W +: ADDR_W];
        w_prot = REQ_PROT[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_done      <= '0;
      r_last      <= IDX_W'(N_REQ - 1);
      r_idx       <= '0;
      r_usr_rdata <= '0;
      r_usr_rresp <= RESP_OKAY;
      r_busy      <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= '0;
      r_arprot    <= '0;
      r_rready    <= 1'b0;
    end else begin
      r_done <= '0;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt     <= w_gnt;
            r_idx     <= w_idx;
            r_araddr  <= w_addr;
            r_arprot  <= w_prot;
            r_arvalid <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (r_arvalid && ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (RVALID && r_rready) begin
            r_usr_rdata <= RDATA;
            r_usr_rresp <= RRESP;
            r_done      <= r_gnt;
            r_gnt       <= '0;
            r_rready    <= 1'b0;
            r_busy      <= 1'b0;
            r_last      <= r_idx;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign GNT       = r_gnt;
  assign DONE      = r_done;
  assign USR_RDATA = r_usr_rdata;
  assign USR_RRESP = r_usr_rresp;
  assign BUSY      = r_busy;
  assign ARVALID   = r_arvalid;
  assign ARADDR    = r_araddr;
  assign ARPROT    = r_arprot;
  assign RREADY    = r_rready;

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Scoreboard bench: a transaction-level model predicts AR issues and completions; a monitor checks.
module tb_axi4_lite_read_arbiter;
  import axi4_lite_pkg::*;

  localparam int unsigned N_REQ  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic                    clk = 1'b0;
  logic                    aresetn;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*3-1:0]      req_prot;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        done;
  logic [DATA_W-1:0]       usr_rdata;
  logic [1:0]              usr_rresp;
  logic                    busy;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_W-1:0]       araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_W-1:0]       rdata;
  logic [1:0]              rresp;

  always #5 clk = ~clk;

  axi4_lite_read_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .ACLK      (clk),
    .ARESETn   (aresetn),
    .REQ       (req),
    .REQ_ADDR  (req_addr),
    .REQ_PROT  (req_prot),
    .GNT       (gnt),
    .DONE      (done),
    .USR_RDATA (usr_rdata),
    .USR_RRESP (usr_rresp),
    .BUSY      (busy),
    .ARVALID   (arvalid),
    .ARREADY   (arready),
    .ARADDR    (araddr),
    .ARPROT    (arprot),
    .RVALID    (rvalid),
    .RREADY    (rready),
    .RDATA     (rdata),
    .RRESP     (rresp)
  );

  typedef struct {
    logic [N_REQ-1:0]  gnt;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        prot;
    int                cyc;
  } ar_exp_t;

  typedef struct {
    logic [N_REQ-1:0]  done;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    int                cyc;
  } dn_exp_t;

  ar_exp_t exp_ar[$];
  dn_exp_t exp_dn[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Reference model: arbitration and handshakes as transactions, sampled each rising edge.
  bit      m_busy = 1'b0;
  bit      m_ar_ok = 1'b0;
  int      m_last = N_REQ - 1;
  int      m_idx = 0;
  ar_exp_t m_ar;
  dn_exp_t m_dn;

  always @(posedge clk) begin
    cyc++;
    if (!aresetn) begin
      m_busy  = 1'b0;
      m_ar_ok = 1'b0;
      m_last  = N_REQ - 1;
      exp_ar.delete();
      exp_dn.delete();
    end else if (!m_busy) begin
      for (int k = 1; k <= N_REQ; k++) begin
        int c;
        c = (m_last + k) % N_REQ;
        if (!m_busy && req[c]) begin
          m_busy    = 1'b1;
          m_idx     = c;
          m_ar.gnt  = '0;
          m_ar.gnt[c] = 1'b1;
          m_ar.addr = req_addr[c*ADDR_W +: ADDR_W];
          m_ar.prot = req_prot[c*3 +: 3];
          m_ar.cyc  = cyc;
          exp_ar.push_back(m_ar);
        end
      end
    end else if (!m_ar_ok) begin
      if (arready) m_ar_ok = 1'b1;
    end else if (rvalid) begin
      m_dn.done = '0;
      m_dn.done[m_idx] = 1'b1;
      m_dn.data = rdata;
      m_dn.resp = rresp;
      m_dn.cyc  = cyc;
      exp_dn.push_back(m_dn);
      m_last  = m_idx;
      m_busy  = 1'b0;
      m_ar_ok = 1'b0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an AR request or a completion.
  logic              prev_arv = 1'b0;
  logic [ADDR_W-1:0] cur_addr = '0;
  logic [2:0]        cur_prot = '0;
  ar_exp_t           mon_ar;
  dn_exp_t           mon_dn;

  always @(negedge clk) begin
    if (aresetn) begin
      chk("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
      chk("done_onehot0", 64'($onehot0(done)), 64'd1);
      chk("arvalid_rready_excl", 64'(arvalid && rready), 64'd0);
      chk("busy_vs_gnt", 64'(busy), 64'(gnt != '0));
      if (arvalid && !prev_arv) begin
        if (exp_ar.size() == 0) begin
          chk("ar_unexpected", 64'(arvalid), 64'd0);
        end else begin
          mon_ar = exp_ar.pop_front();
          chk("ar_gnt", 64'(gnt), 64'(mon_ar.gnt));
          chk("ar_addr", 64'(araddr), 64'(mon_ar.addr));
          chk("ar_prot", 64'(arprot), 64'(mon_ar.prot));
          chk("ar_cycle", 64'(cyc), 64'(mon_ar.cyc));
          cur_addr = mon_ar.addr;
          cur_prot = mon_ar.prot;
        end
      end else if (arvalid) begin
        chk("ar_addr_stable", 64'({arprot, araddr}), 64'({cur_prot, cur_addr}));
      end
      if (done != '0) begin
        if (exp_dn.size() == 0) begin
          chk("done_unexpected", 64'(done), 64'd0);
        end else begin
          mon_dn = exp_dn.pop_front();
          chk("done_mask", 64'(done), 64'(mon_dn.done));
          chk("done_rdata", 64'(usr_rdata), 64'(mon_dn.data));
          chk("done_rresp", 64'(usr_rresp), 64'(mon_dn.resp));
          chk("done_cycle", 64'(cyc), 64'(mon_dn.cyc));
        end
      end
    end
    prev_arv = arvalid;
  end

  task automatic wait_done(output logic [N_REQ-1:0] d);
    d = '0;
    for (int i = 0; i < 20 && d == '0; i++) begin
      step();
      d = done;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N_REQ-1:0] d;
    int arv_cnt, rr_cnt, done_at, cnt;

    aresetn  = 1'b0;
    req      = '0;
    req_addr = '0;
    req_prot = '0;
    arready  = 1'b0;
    rvalid   = 1'b0;
    rdata    = '0;
    rresp    = RESP_OKAY;
    repeat (3) @(posedge clk);
    step();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_araddr", 64'({arprot, araddr}), 64'd0);
    chk("rst_usr", 64'({usr_rresp, usr_rdata}), 64'd0);
    aresetn = 1'b1;
    step();

    // Single request with an immediately responding slave.
    arready = 1'b1;
    rvalid  = 1'b1;
    rdata   = 32'hDEAD_BEEF;
    req_addr[0 +: ADDR_W] = 32'h0000_1000;
    req_prot[0 +: 3] = 3'd5;
    req = 4'b0001;
    step();
    chk("single_arvalid", 64'(arvalid), 64'd1);
    chk("single_araddr", 64'(araddr), 64'h1000);
    chk("single_gnt", 64'(gnt), 64'd1);
    step();
    chk("single_rready", 64'(rready), 64'd1);
    step();
    chk("single_done", 64'(done), 64'd1);
    chk("single_rdata", 64'(usr_rdata), 64'hDEAD_BEEF);
    req = '0;
    step();
    chk("single_done_pulse", 64'(done), 64'd0);
    chk("single_idle", 64'(busy), 64'd0);

    // Error response passes through; the next requester is served normally.
    rresp = RESP_SLVERR;
    rdata = 32'h1234_5678;
    req_addr[ADDR_W +: ADDR_W] = 32'h0000_2004;
    req = 4'b0010;
    wait_done(d);
    chk("slverr_done", 64'(d), 64'b0010);
    chk("slverr_resp", 64'(usr_rresp), 64'(RESP_SLVERR));
    rresp = RESP_OKAY;
    req_addr[2*ADDR_W +: ADDR_W] = 32'h0000_3008;
    req = 4'b0100;
    wait_done(d);
    chk("after_slverr_done", 64'(d), 64'b0100);
    chk("after_slverr_resp", 64'(usr_rresp), 64'(RESP_OKAY));
    req = '0;
    step();

    // Slow slave: AR accepted on the 6th edge with ARVALID, R three edges after RREADY rises.
    arready = 1'b0;
    rvalid  = 1'b0;
    req_addr[0 +: ADDR_W] = 32'h0000_4000;
    req = 4'b0001;
    arv_cnt = 0;
    rr_cnt  = 0;
    done_at = 0;
    for (int j = 1; j <= 13; j++) begin
      step();
      if (arvalid) arv_cnt++;
      if (rready) rr_cnt++;
      if (done != '0 && done_at == 0) begin
        done_at = j;
        req = '0;
      end
      arready = (j == 6);
      rvalid  = (j == 10);
    end
    chk("slow_arvalid_cycles", 64'(arv_cnt), 64'd6);
    chk("slow_rready_cycles", 64'(rr_cnt), 64'd4);
    chk("slow_done_latency", 64'(done_at), 64'd11);

    // Requester drops REQ while in ADDR: transaction still completes.
    req_addr[ADDR_W +: ADDR_W] = $urandom;
    req = 4'b0010;
    step();
    chk("drop_gnt", 64'(gnt), 64'b0010);
    req = '0;
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid  = 1'b1;
    step();
    chk("drop_done", 64'(done), 64'b0010);
    rvalid = 1'b0;
    step();

    // Reset in DATA aborts with no DONE and restores the pointer.
    req_addr[2*ADDR_W +: ADDR_W] = 32'h0000_5000;
    req = 4'b0100;
    arready = 1'b1;
    step();
    step();
    arready = 1'b0;
    chk("pre_rst_gnt", 64'(gnt), 64'b0100);
    chk("pre_rst_rready", 64'(rready), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({gnt, done, arvalid, rready, busy}), 64'd0);
    chk("midrst_ar", 64'({arprot, araddr}), 64'd0);
    chk("midrst_usr", 64'({usr_rresp, usr_rdata}), 64'd0);
    req = 4'b0101;
    step();
    step();
    aresetn = 1'b1;
    arready = 1'b1;
    rvalid  = 1'b1;
    step();
    chk("ptr_reset_gnt", 64'(gnt), 64'b0001);

    // All four requesting continuously: strict rotation 0,1,2,3,...
    req = 4'b1111;
    cnt = 0;
    for (int j = 0; j < 60 && cnt < 8; j++) begin
      step();
      if (done != '0) begin
        chk($sformatf("rr_order%0d", cnt), 64'(done), 64'(1 << (cnt % 4)));
        cnt++;
      end
    end
    chk("rr_order_count", 64'(cnt), 64'd8);

    // Randomized requesters and slave.
    for (int n = 0; n < 3000; n++) begin
      step();
      arready = ($urandom_range(0, 3) != 0);
      rvalid  = ($urandom_range(0, 4) < 3);
      rdata   = $urandom;
      rresp   = 2'($urandom_range(0, 3));
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          if (done[i]) begin
            if ($urandom_range(0, 1) == 1) begin
              req_addr[i*ADDR_W +: ADDR_W] = $urandom;
              req_prot[i*3 +: 3] = 3'($urandom_range(0, 7));
            end else begin
              req[i] = 1'b0;
            end
          end else if ($urandom_range(0, 99) < 3) begin
            req[i] = 1'b0;
          end else if ($urandom_range(0, 9) == 0) begin
            req_addr[i*ADDR_W +: ADDR_W] = $urandom;
          end
        end else if ($urandom_range(0, 9) < 3) begin
          req[i] = 1'b1;
          req_addr[i*ADDR_W +: ADDR_W] = $urandom;
          req_prot[i*3 +: 3] = 3'($urandom_range(0, 7));
        end
      end
    end

    req = '0;
    arready = 1'b1;
    rvalid  = 1'b1;
    repeat (10) step();
    chk("drain_ar_queue", 64'(exp_ar.size()), 64'd0);
    chk("drain_done_queue", 64'(exp_dn.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_read_arbiter.md
Name: axi4_lite_read_arbiter

Overview:
- Shares one AXI4-Lite master read port (AR and R channels) between N_REQ local requesters.
- Each requester raises a request with an address and receives a one-cycle completion pulse with captured read data and response.
- Round-robin arbitration; one outstanding transaction at a time.
- Sits between user-side control logic and the AXI4-Lite read interface in the bench and system fabric.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width (32 or 64).

Ports:
- ACLK  in  1  clock, rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- REQ  in  N_REQ  per-requester request level; held until the matching DONE bit.
- REQ_ADDR  in  N_REQ*ADDR_W  packed addresses; slice i belongs to requester i.
- REQ_PROT  in  N_REQ*3  packed ARPROT values.
- GNT  out  N_REQ  one-hot; the requester currently owning the port.
- DONE  out  N_REQ  one-hot, one-cycle completion pulse.
- USR_RDATA  out  DATA_W  read data; valid while DONE is nonzero, held until the next completion.
- USR_RRESP  out  2  response; same timing as USR_RDATA.
- BUSY  out  1  high in any state other than IDLE.
- ARVALID  out  1  AXI AR valid.
- ARREADY  in  1  AXI AR ready.
- ARADDR  out  ADDR_W  AXI read address.
- ARPROT  out  3  AXI protection.
- RVALID  in  1  AXI R valid.
- RREADY  out  1  AXI R ready.
- RDATA  in  DATA_W  AXI read data.
- RRESP  in  2  AXI read response.

Behaviour:
- Reset (ARESETn low, asynchronous):
  - GNT, DONE, ARVALID, RREADY, BUSY, USR_RDATA, USR_RRESP, ARADDR and ARPROT all go to 0.
  - State goes to IDLE; round-robin pointer LAST goes to N_REQ-1, so requester 0 has priority first.
- All outputs are registered.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - If any REQ bit is set, select the first set bit searching LAST+1, LAST+2, … modulo N_REQ.
  - On the next edge: latch the index into GNT; drive ARADDR/ARPROT from that slice; ARVALID=1; BUSY=1; go to ADDR.
  - Latency is REQ high at edge k to ARVALID high after edge k.
- ADDR:
  - ARVALID, ARADDR and ARPROT stay stable until an edge with ARVALID&&ARREADY (AXI rule; never withdrawn).
  - On that edge: ARVALID=0, RREADY=1, go to DATA.
- DATA:
  - RREADY stays 1 until an edge with RVALID&&RREADY.
  - On that edge: USR_RDATA<=RDATA, USR_RRESP<=RRESP; DONE<=GNT for exactly one cycle; GNT<=0; RREADY=0; BUSY=0; LAST<=granted index; go to IDLE.
- Minimum transaction time:
  - 3 cycles from REQ to DONE when ARREADY and RVALID are each high on the first possible edge.
  - The next grant can start on the cycle DONE is high, so throughput is one transaction per 3 cycles.
- REQ dropped mid-transaction: ignored. The transaction completes and DONE is still pulsed.
- REQ_ADDR changes after the grant: ignored; the address is latched at grant.
- Same requester re-requests on the DONE cycle: it is eligible only after all other pending requesters (round-robin fairness). It is granted back-to-back if it is the sole requester.
- RRESP: passed through unmodified (SLVERR/DECERR included). No retry.
- RVALID high while in IDLE or ADDR: ignored (protocol violation; RREADY stays low).
- Reset mid-transaction: the FSM aborts to IDLE with no DONE. The slave is reset by the same ARESETn.
- Invariants: GNT is 0 or one-hot. DONE is 0 or one-hot. ARVALID and RREADY are never both 1.

Decomposition:
- Package axi4_lite_pkg holds:
  - typedef enum logic [1:0] {IDLE, ADDR, DATA} rd_arb_state_t.
  - localparam RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- One sub-module, rr_arbiter_core:
  - Combinational round-robin priority select.
  - Inputs: request vector, LAST pointer.
  - Outputs: one-hot grant, binary index, any-valid.
  - Reusable for the write-channel arbiter.

Test Plan:
- Single request: REQ=4'b0001, REQ_ADDR[0]=32'h0000_1000, ARREADY and RVALID responding immediately, RDATA=32'hDEAD_BEEF, RRESP=0 -> ARADDR=32'h1000 one cycle after REQ; DONE=4'b0001 pulse 3 cycles after REQ; USR_RDATA=32'hDEAD_BEEF.
- All four requesting continuously -> grant order 0,1,2,3,0,…; each DONE bit is pulsed exactly once per 4 transactions.
- ARREADY delayed 5 cycles, RVALID delayed 3 cycles after the AR handshake -> ARVALID held for 6 cycles with ARADDR stable; RREADY held for 4 cycles; DONE 11 cycles after REQ.
- Slave returns RRESP=2'b10 -> USR_RRESP=2'b10 alongside DONE; the next requester is served normally.
- ARESETn pulled low while in DATA with GNT=4'b0100 -> all outputs 0 immediately; no DONE; after release REQ[2] is granted first only if REQ[0] and REQ[1] are low (pointer reset).
- REQ[1] dropped while in ADDR -> the transaction still completes and DONE=4'b0010 is pulsed.
